// File: rtl/result_bcd_display_pkg.sv
// rtl/result_bcd_display_pkg.sv - shared types and segment patterns for result_bcd_display
//
// Purpose: converter FSM state type and active-high seven-segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}. Output polarity is applied by the top.
// Ports: none (package).
package result_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/result_bcd_display_bcd_to_seg7.sv
// rtl/result_bcd_display_bcd_to_seg7.sv - one BCD digit to active-high seven-segment pattern
//
// Purpose: combinational decode of a single BCD digit.
// Ports:
//   digit  in   4  BCD digit 0-9 (10-15 decode as all segments off)
//   blank  in   1  force all segments off
//   seg    out  7  active-high {g,f,e,d,c,b,a}
module bcd_to_seg7
  import result_bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_bcd_display.sv
// rtl/result_bcd_display.sv - iterative binary-to-BCD converter driving seven-segment digits
//
// Purpose: captures result on start (IDLE only), runs double dabble one bit
// per cycle for WIDTH cycles, then publishes the digits in the DONE cycle.
// bcd/seg hold the previous value until the next conversion completes.
// Optional macro RESULT_BCD_LEADING_ZERO_BLANK_EN: blank leading-zero digits
// on seg (digit 0 always shown); bcd is unaffected.
// Ports:
//   clk     in   1          rising-edge clock
//   rst_n   in   1          asynchronous active-low reset
//   start   in   1          conversion request, honoured only in IDLE
//   result  in   WIDTH      binary value, sampled on the accepting edge
//   busy    out  1          high while shifting
//   done    out  1          one-cycle pulse with fresh bcd/seg
//   bcd     out  4*DIGITS   packed BCD, ones digit in [3:0]
//   seg     out  7*DIGITS   packed segments per digit, digit 0 in [6:0]
module result_bcd_display
  import result_bcd_display_pkg::*;
#(
  parameter int WIDTH          = 9,
  parameter int DIGITS         = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;

    // Add-3 correction: any digit >= 5 would exceed 9 after doubling.
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = result;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // done is registered so it lines up with the new bcd value.
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_raw;

`ifdef RESULT_BCD_LEADING_ZERO_BLANK_EN
  logic zero_run;
  // Walk down from the top digit; a digit blanks only while every digit
  // above it (and itself) is zero. Digit 0 is never blanked.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (bcd_q[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_to_seg7 u_seg (
      .digit (bcd_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_raw[7*g +: 7])
    );
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

endmodule

// File: doc/result_bcd_display.md
Name: result_bcd_display

Overview:
- Downstream consumer of the 9-bit arithmetic-unit result.
- Captures a binary result on a start pulse and converts it to BCD iteratively, using shift-and-add-3 (double dabble), one bit per cycle.
- Drives three seven-segment digit outputs for the board display.
- Holds the last converted value stable between conversions so the display never flickers mid-conversion.

Parameters:
- WIDTH, 9, binary input width; must satisfy 2^WIDTH-1 < 10^DIGITS.
- DIGITS, 3, number of BCD digits and seven-segment outputs.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (board LEDs); 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion of result; sampled only in IDLE
- result  input  WIDTH  binary value from the arithmetic unit; sampled on the accepting edge only
- busy  output  1  high while a conversion is in progress (SHIFT state)
- done  output  1  one-cycle pulse when new digits are valid
- bcd  output  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]
- seg  output  7*DIGITS  packed segments {g,f,e,d,c,b,a} per digit, digit 0 in [6:0]

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0, bcd=0.
  - seg shows "000", or "  0" with the optional feature enabled.
  - Internal shift register and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch result into the shift register, clear the scratch BCD, set counter=WIDTH-1, go to SHIFT. On start=0, stay.
- SHIFT, each cycle:
  - First, for each scratch digit >=5, add 3.
  - Then shift {scratch, shreg} left by 1.
  - Counter=0 -> go to DONE; otherwise decrement.
  - Exactly WIDTH cycles in SHIFT.
- DONE: copy scratch to the bcd output register, assert done for this cycle only, go to IDLE.
- Latency:
  - Start sampled at edge k -> busy=1 from k+1 until edge k+WIDTH+1.
  - done=1 and new bcd/seg visible after edge k+WIDTH+1 (edge k+10 for WIDTH=9), for one cycle.
- Handshake and boundary rules:
  - start while busy or in DONE is ignored, with no queuing.
  - start held high continuously re-triggers on every IDLE visit; one conversion per WIDTH+2 cycles.
  - result changing during a conversion has no effect.
  - bcd/seg are registered and change only on the DONE cycle; otherwise they hold the previous value.
- Seg decode:
  - Combinational from the bcd register; standard 0-9 patterns.
  - Codes 10-15 are unreachable; decode them as all segments off.
- Reset mid-conversion: immediate return to reset values; the partial result is discarded, with no done pulse.
- Maximum input 511 -> 5,1,1; no overflow is possible under the parameter constraint.

Optional Feature:
- Macro: RESULT_BCD_LEADING_ZERO_BLANK_EN.
- Defined: leading-zero digits are blanked (all segments off, polarity per SEG_ACTIVE_LOW).
  - A digit blanks only if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - bcd output is unaffected.
- Undefined: every digit is always decoded, so leading zeros are shown.

Decomposition:
- Shared package holds:
  - state typedef {IDLE, SHIFT, DONE};
  - seven-segment pattern constants for 0-9 and blank, active-high form; polarity is applied at the output.
- One natural sub-module: bcd_to_seg7, combinational, 4-bit digit plus blank input -> 7-bit segments; instantiated DIGITS times in a generate loop.
- Add-3 correction and the FSM stay inline.

Test Plan:
- Reset -> busy=0, done=0, bcd=12'h000, seg = three '0' patterns (active-low 7'b1000000 each), checked both during rst_n=0 and after release.
- result=9'd511, start pulse -> done after exactly 10 edges, bcd=12'h511, seg digits "5","1","1"; busy high for exactly 9 cycles.
- result=9'd0 then 9'd100 then 9'd99 back-to-back, start held high -> bcd 000, 100, 099 in order, done pulses spaced 11 cycles apart.
- Start pulses and result changes to 9'd7 during busy of a 9'd256 conversion -> single done, bcd=12'h256; extra starts ignored.
- rst_n low on the 4th SHIFT cycle of a 9'd345 conversion -> no done pulse, bcd=000; a new start afterwards converts 345 correctly.
- With RESULT_BCD_LEADING_ZERO_BLANK_EN: 9'd7 -> hundreds and tens blank, ones "7"; 9'd105 -> all three digits shown, tens "0"; 9'd0 -> only ones "0" lit.
